// File: rtl/instr_issue.sv
// Instruction FIFO with a waiting/start handshake to the controller and registered decode outputs.
// Optional build macro INSTR_ISSUE_ILLEGAL_DROP_EN drops head words whose opcode is not 110/101.
module instr_issue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [15:0]              in_instr,
    output logic                     in_ready,
    input  logic                     waiting,
    output logic                     start,
    output logic [2:0]               opcode,
    output logic [1:0]               ALU_op,
    output logic [1:0]               shift_op,
    output logic [2:0]               rn,
    output logic [2:0]               rd,
    output logic [2:0]               rm,
    output logic [15:0]              sximm8,
    output logic [15:0]              sximm5,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     instr_q;
    logic            start_q;
    logic [15:0]     head;
    logic            head_legal;
    logic            enq, deq, issue, drop;

    assign head     = mem_q[rptr_q];
    assign in_ready = (count_q != FULL);
    assign enq      = in_valid && in_ready;
    assign deq      = issue || drop;

`ifdef INSTR_ISSUE_ILLEGAL_DROP_EN
    logic err_q;
    assign head_legal  = (head[15:13] == 3'b110) || (head[15:13] == 3'b101);
    assign err_illegal = err_q;
`else
    assign head_legal  = 1'b1;
    assign err_illegal = 1'b0;
`endif

    // Issue only from the registered occupancy, so a word written this edge waits one more edge.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (!head_legal) begin
                        drop = 1'b1;
                    end else if (waiting) begin
                        issue   = 1'b1;
                        state_d = WAIT_BUSY;
                    end
                end
            end
            WAIT_BUSY: begin
                if (!waiting) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (waiting) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            instr_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            start_q <= issue;
            if (enq) wptr_q <= wptr_q + AW'(1);
            if (deq) rptr_q <= rptr_q + AW'(1);
            if (issue) instr_q <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) mem_q[wptr_q] <= in_instr;
    end

`ifdef INSTR_ISSUE_ILLEGAL_DROP_EN
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= drop;
    end
`endif

    assign start    = start_q;
    assign count    = count_q;
    assign opcode   = instr_q[15:13];
    assign ALU_op   = instr_q[12:11];
    assign rn       = instr_q[10:8];
    assign rd       = instr_q[7:5];
    assign shift_op = instr_q[4:3];
    assign rm       = instr_q[2:0];
    assign sximm8   = {{8{instr_q[7]}}, instr_q[7:0]};
    assign sximm5   = {{11{instr_q[4]}}, instr_q[4:0]};

endmodule

// File: tb/tb_instr_issue.sv
// Directed bench for instr_issue: a queue-based reference model checked every cycle,
// plus literal checkpoints at the handshake milestones.
module tb_instr_issue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = '0;
    logic        in_ready;
    logic        waiting = 1'b0;
    logic        start;
    logic [2:0]  opcode;
    logic [1:0]  ALU_op;
    logic [1:0]  shift_op;
    logic [2:0]  rn, rd, rm;
    logic [15:0] sximm8, sximm5;
    logic [$clog2(DEPTH):0] count;
    logic        err_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    instr_issue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .waiting(waiting), .start(start),
        .opcode(opcode), .ALU_op(ALU_op), .shift_op(shift_op),
        .rn(rn), .rd(rd), .rm(rm), .sximm8(sximm8), .sximm5(sximm5),
        .count(count), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] mq[$];
    logic [15:0] m_word  = '0;
    logic        m_start = 1'b0;
    logic        m_err   = 1'b0;
    int          m_phase = 0;   // 0: ready to issue, 1: expect waiting low, 2: expect waiting high
    bit          m_valid = 1'b0;

    function automatic bit legal(input logic [15:0] w);
`ifdef INSTR_ISSUE_ILLEGAL_DROP_EN
        return (w[15:13] == 3'd6) || (w[15:13] == 3'd5);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] v, input int bits);
        logic [15:0] r;
        r = v & ((16'd1 << bits) - 16'd1);
        if (v[bits-1]) r = r - (16'd1 << bits);
        return r;
    endfunction

    always @(posedge clk) begin
        int pre;
        bit iss, drp;
        logic [15:0] w;
        if (rst) begin
            mq.delete();
            m_word = '0; m_start = 1'b0; m_err = 1'b0; m_phase = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            pre = mq.size();
            iss = 1'b0; drp = 1'b0;
            if (m_phase == 0 && pre > 0) begin
                if (!legal(mq[0]))  drp = 1'b1;
                else if (waiting)   iss = 1'b1;
            end
            if (m_phase == 1 && !waiting) m_phase = 2;
            else if (m_phase == 2 && waiting) m_phase = 0;
            if (iss || drp) begin
                w = mq.pop_front();
                if (iss) begin m_word = w; m_phase = 1; end
            end
            m_start = iss;
            m_err   = drp;
            if (in_valid && pre != DEPTH) mq.push_back(in_instr);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("count",    32'(count),    32'(mq.size()));
            chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
            chk("start",    32'(start),    32'(m_start));
            chk("err",      32'(err_illegal), 32'(m_err));
            chk("opcode",   32'(opcode),   32'(m_word >> 13));
            chk("ALU_op",   32'(ALU_op),   32'((m_word >> 11) & 16'h3));
            chk("rn",       32'(rn),       32'((m_word >> 8) & 16'h7));
            chk("rd",       32'(rd),       32'((m_word >> 5) & 16'h7));
            chk("shift_op", 32'(shift_op), 32'((m_word >> 3) & 16'h3));
            chk("rm",       32'(rm),       32'(m_word & 16'h7));
            chk("sximm8",   32'(sximm8),   32'(sext(m_word, 8)));
            chk("sximm5",   32'(sximm5),   32'(sext(m_word, 5)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        in_valid = 1'b1;
        in_instr = w;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_start", 32'(start), 0);
        chk("rst_imm8",  32'(sximm8), 0);

        // MOV R1,#5: written at one edge, issued at the next
        waiting = 1'b1;
        push(16'hD105);
        chk("nobypass_cnt", 32'(count), 1);
        chk("nobypass_st",  32'(start), 0);
        step();
        chk("mov_start", 32'(start), 1);
        chk("mov_op",    32'(opcode), 32'h6);
        chk("mov_alu",   32'(ALU_op), 32'h2);
        chk("mov_rn",    32'(rn), 1);
        chk("mov_imm8",  32'(sximm8), 32'h0005);
        chk("mov_cnt",   32'(count), 0);

        // waiting held high: no second start
        push(16'hD2FE);
        chk("busy_st0", 32'(start), 0);
        step(); step();
        chk("busy_st1", 32'(start), 0);
        waiting = 1'b0; step(); step();
        waiting = 1'b1; step();
        chk("idle_entry_st", 32'(start), 0);
        step();
        chk("neg_start", 32'(start), 1);
        chk("neg_imm8",  32'(sximm8), 32'hFFFE);

        waiting = 1'b0; step();
        waiting = 1'b1; step();
        push(16'hA0A4);
        step();
        chk("add_start", 32'(start), 1);
        chk("add_op",    32'(opcode), 32'h5);
        chk("add_imm5",  32'(sximm5), 32'h0004);
        chk("add_sh",    32'(shift_op), 0);
        chk("add_rd",    32'(rd), 5);
        chk("add_rm",    32'(rm), 4);

        // fill to full, overflow word dropped
        waiting = 1'b0; step();
        for (int k = 1; k <= 4; k++) push(16'hD000 | 16'(k));
        chk("full_cnt",   32'(count), 4);
        chk("full_ready", 32'(in_ready), 0);
        push(16'hD0FF);
        chk("drop_cnt",   32'(count), 4);
        waiting = 1'b1; step(); step();
        chk("q1_start", 32'(start), 1);
        chk("q1_imm8",  32'(sximm8), 1);
        chk("q1_ready", 32'(in_ready), 1);
        for (int k = 2; k <= 4; k++) begin
            waiting = 1'b0; step();
            waiting = 1'b1; step(); step();
            chk("qk_start", 32'(start), 1);
            chk("qk_imm8",  32'(sximm8), 32'(k));
        end
        chk("drained_cnt", 32'(count), 0);

        // simultaneous enqueue and issue
        waiting = 1'b0; step();
        waiting = 1'b1;
        push(16'hD011);
        push(16'hD022);
        chk("simul_cnt",   32'(count), 1);
        chk("simul_start", 32'(start), 1);
        chk("simul_imm8",  32'(sximm8), 32'h11);

        // reset in WAIT_DONE with 3 queued, concurrent push ignored
        waiting = 1'b0; step();
        push(16'hD031);
        push(16'hD032);
        chk("pre_rst_cnt", 32'(count), 3);
        rst = 1'b1; in_valid = 1'b1; in_instr = 16'hD0AA;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("mid_rst_cnt",   32'(count), 0);
        chk("mid_rst_start", 32'(start), 0);
        chk("mid_rst_op",    32'(opcode), 0);
        chk("mid_rst_rn",    32'(rn), 0);
        chk("mid_rst_imm8",  32'(sximm8), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);

        // illegal opcode followed by MOV
        waiting = 1'b1;
        push(16'h0000);
        push(16'hD105);
`ifdef INSTR_ISSUE_ILLEGAL_DROP_EN
        chk("ill_err",   32'(err_illegal), 1);
        chk("ill_start", 32'(start), 0);
        chk("ill_cnt",   32'(count), 1);
        step();
        chk("ill_next_start", 32'(start), 1);
        chk("ill_next_err",   32'(err_illegal), 0);
        chk("ill_next_op",    32'(opcode), 32'h6);
`else
        chk("zero_start", 32'(start), 1);
        chk("zero_op",    32'(opcode), 0);
        chk("zero_err",   32'(err_illegal), 0);
        chk("zero_cnt",   32'(count), 1);
        waiting = 1'b0; step();
        waiting = 1'b1; step(); step();
        chk("mov2_start", 32'(start), 1);
        chk("mov2_op",    32'(opcode), 32'h6);
`endif
        step(); step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 Parameter: DEPTH, default 4, instruction FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream instruction word valid.
REQ-005 in_instr  input  16  instruction word; fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0], imm5[4:0].
REQ-006 in_ready  output  1  FIFO can accept a word this cycle.
REQ-007 waiting  input  1  controller in wait state.
REQ-008 start  output  1  one-cycle issue pulse to controller.
REQ-009 opcode  output  3  issued opcode.
REQ-010 ALU_op  output  2  issued op field.
REQ-011 shift_op  output  2  issued sh field.
REQ-012 rn, rd, rm  output  3 each  issued register fields.
REQ-013 sximm8, sximm5  output  16 each  sign-extended imm8 / imm5 of issued word.
REQ-014 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 err_illegal  output  1  one-cycle pulse, illegal word dropped (macro only).

Function
REQ-016 Enqueue when in_valid && in_ready at clock edge; in_ready = (count != DEPTH), no bypass of full even on same-cycle dequeue.
REQ-017 No enqueue-to-issue bypass: word written into empty FIFO at edge N is issuable no earlier than edge N+1.
REQ-018 FSM states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if count>0 && waiting==1, at edge dequeue head, load all decode outputs, assert start for exactly the following cycle, go WAIT_BUSY.
REQ-020 WAIT_BUSY: start=0; stay until waiting==0, then go WAIT_DONE.
REQ-021 WAIT_DONE: stay until waiting==1, then go IDLE; next issue at earliest the edge after entering IDLE.
REQ-022 Decode outputs held stable from issue until next issue; changed only on dequeue.
REQ-023 Simultaneous enqueue and dequeue when not full: both occur, count unchanged.
REQ-024 Read/write pointers wrap modulo DEPTH; FIFO order strictly preserved.
REQ-025 in_valid while full: word dropped, no state change.
REQ-026 Sign extension: sximm8 = {{8{imm8[7]}},imm8}; sximm5 = {{11{imm5[4]}},imm5}.

Reset
REQ-027 rst high at edge: FIFO emptied (count=0), pointers 0, FSM IDLE, start=0, err_illegal=0, all decode outputs 0.
REQ-028 rst overrides simultaneous enqueue/issue; mid-instruction reset discards queued and in-flight words.
REQ-029 in_ready = 1 in the first cycle after reset.

Configuration
REQ-030 Macro INSTR_ISSUE_ILLEGAL_DROP_EN defined: head word with opcode not in {110,101}, in IDLE, dequeued without start, decode outputs unchanged, err_illegal pulsed one cycle, FSM stays IDLE, independent of waiting.
REQ-031 Macro undefined: all opcodes issued per REQ-019; err_illegal tied 0.

Verification
REQ-032 Reset then push 0xD105 (MOV R1,#5) with waiting=1 -> start pulses one cycle, opcode=110, ALU_op=10, rn=1, sximm8=0x0005, count back to 0.
REQ-033 Push 0xD2FE -> sximm8=0xFFFE; push 0xA0A4 (ADD R5,R0,R4 LSL) -> sximm5 of imm5 00100 = 0x0004, shift_op=00, rd=5, rm=4.
REQ-034 Push 4 words, waiting=0 -> count=4, in_ready=0, 5th word dropped; then waiting=1 -> four issues in FIFO order, each only after waiting 1->0->1 cycle, in_ready=1 after first dequeue.
REQ-035 Hold waiting=1 after start -> FSM stays WAIT_BUSY, no second start; drop waiting 2 cycles then raise -> next start one cycle after IDLE entry.
REQ-036 Assert rst during WAIT_DONE with 3 queued -> next cycle count=0, start=0, all outputs 0, in_ready=1.
REQ-037 With INSTR_ISSUE_ILLEGAL_DROP_EN, push 0x0000 then 0xD105 -> err_illegal pulse, no start for first, start for second; without macro both issue.
